// File: rtl/thumb_prefetch.sv
// rtl/thumb_prefetch.sv - Thumb instruction prefetch buffer with halfword FIFO and branch redirect
module thumb_prefetch #(
    parameter int          BUS_WIDTH = 32,
    parameter int          DEPTH     = 8,
    parameter logic [31:0] RESET_PC  = 32'h0800_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_rvalid,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    output logic [31:0]          instr,
    output logic                 instr_is32,
    output logic [31:0]          instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 branch_valid,
    input  logic [31:0]          branch_target
);
    localparam int BEATS = BUS_WIDTH / 16;
    localparam int OFFW  = $clog2(BUS_WIDTH / 8);
    localparam int SKW   = OFFW - 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam logic [31:0]   ALIGN_MASK = ~32'(BUS_WIDTH / 8 - 1);
    localparam logic [31:0]   STRIDE     = 32'(BUS_WIDTH / 8);
    localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH - BEATS);

    logic [15:0]    hw_q [DEPTH];
    logic [31:0]    pc_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    fetch_addr_q, mem_addr_q;
    logic [SKW-1:0] skip_q;
    logic           outstanding_q, drop_q, mem_req_q;

    logic [15:0]   hw0, hw1;
    logic          head_lead, rvalid_ok, push_en, issue;
    logic [CW-1:0] push_n, pop_n;

    always_comb begin
        hw0         = hw_q[rd_ptr_q];
        hw1         = hw_q[rd_ptr_q + PW'(1)];
        head_lead   = (hw0[15:13] == 3'b111) && (hw0[12:11] != 2'b00);
        // a lone 32-bit lead waits for its second half rather than being split
        instr_valid = (count_q >= CW'(2)) || ((count_q == CW'(1)) && !head_lead);
        instr_is32  = instr_valid && head_lead;
        instr       = !instr_valid ? 32'h0 : (head_lead ? {hw0, hw1} : {16'h0, hw0});
        instr_pc    = instr_valid ? pc_q[rd_ptr_q] : 32'h0;

        // rvalid with nothing outstanding (e.g. a read killed by reset) is ignored
        rvalid_ok = mem_rvalid && outstanding_q;
        push_en   = rvalid_ok && !drop_q && !branch_valid;
        push_n    = push_en ? (CW'(BEATS) - CW'(skip_q)) : '0;
        pop_n     = (instr_valid && instr_ready) ? (head_lead ? CW'(2) : CW'(1)) : '0;
        count_d   = count_q + push_n - pop_n;
        issue     = !branch_valid && (!outstanding_q || rvalid_ok) && (count_d <= FILL_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_addr_q  <= RESET_PC & ALIGN_MASK;
            mem_addr_q    <= RESET_PC & ALIGN_MASK;
            skip_q        <= RESET_PC[OFFW-1:1];
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            mem_req_q     <= 1'b0;
        end else begin
            mem_req_q <= issue;
            if (issue) begin
                mem_addr_q    <= fetch_addr_q;
                fetch_addr_q  <= fetch_addr_q + STRIDE;
                outstanding_q <= 1'b1;
            end else if (rvalid_ok) begin
                outstanding_q <= 1'b0;
            end

            if (branch_valid) begin
                rd_ptr_q     <= '0;
                wr_ptr_q     <= '0;
                count_q      <= '0;
                fetch_addr_q <= branch_target & ALIGN_MASK;
                skip_q       <= branch_target[OFFW-1:1];
                // a read still in flight after this edge returns stale data
                drop_q       <= outstanding_q && !rvalid_ok;
            end else begin
                count_q  <= count_d;
                rd_ptr_q <= rd_ptr_q + PW'(pop_n);
                wr_ptr_q <= wr_ptr_q + PW'(push_n);
                if (rvalid_ok) begin
                    drop_q <= 1'b0;
                    if (!drop_q) begin
                        skip_q <= '0;
                    end
                end
            end

            if (push_en) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (b >= int'(skip_q)) begin
                        hw_q[wr_ptr_q + PW'(b - int'(skip_q))] <= mem_rdata[16*b +: 16];
                        pc_q[wr_ptr_q + PW'(b - int'(skip_q))] <= mem_addr_q + 32'(2 * b);
                    end
                end
            end
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
endmodule

// File: doc/thumb_prefetch.md
THUMB_PREFETCH -- requirements
Module: thumb_prefetch

Interface
REQ-001 Parameter BUS_WIDTH, default 32, memory read width in bits; legal values 32 or 64; BEATS = BUS_WIDTH/16 halfwords per read.
REQ-002 Parameter DEPTH, default 8, halfword buffer entries; power of two, at least 2*BEATS.
REQ-003 Parameter RESET_PC, default 32'h08000000, halfword-aligned fetch start address.
REQ-004 clk  input  1  the block's single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_req  output  1  read request, one-cycle pulse.
REQ-007 mem_addr  output  32  read address, BUS_WIDTH/8-byte aligned, valid while mem_req is high.
REQ-008 mem_rvalid  input  1  read data valid; at least one cycle after mem_req, arbitrary wait states allowed.
REQ-009 mem_rdata  input  BUS_WIDTH  read data, little-endian; lowest halfword is at the lowest address.
REQ-010 instr  output  32  current instruction; 16-bit form {16'h0, hw0}; 32-bit form {hw0, hw1}.
REQ-011 instr_is32  output  1  instr is a 32-bit Thumb-2 encoding.
REQ-012 instr_pc  output  32  address of hw0 of instr.
REQ-013 instr_valid  output  1  instr, instr_is32 and instr_pc are valid.
REQ-014 instr_ready  input  1  decoder accepts instr; transfer occurs when instr_valid and instr_ready are both high.
REQ-015 branch_valid  input  1  redirect request, one cycle.
REQ-016 branch_target  input  32  redirect address; bit 0 is ignored.

Function
REQ-017 The block SHALL hold a halfword FIFO of DEPTH entries, each storing the halfword and its address, with first-word-fall-through output.
REQ-018 At most one read SHALL be outstanding; mem_req SHALL be a registered signal.
REQ-019 mem_req SHALL assert when all of the following hold: nothing is outstanding (or mem_rvalid is high this cycle), and the post-update free entries are at least BEATS.
REQ-020 After each issued read, fetch_addr SHALL advance by BUS_WIDTH/8 and wrap modulo 2^32.
REQ-021 On mem_rvalid, the block SHALL push halfwords in ascending address order, skipping the first `skip` halfwords, then clear skip to 0.
REQ-022 A halfword SHALL be classified as a 32-bit lead when hw[15:11] is 5'b11101, 5'b11110 or 5'b11111.
REQ-023 instr_valid SHALL be high when count >= 1 and the head halfword is not a 32-bit lead, or when count >= 2.
REQ-024 A transfer SHALL pop 1 halfword, or 2 when instr_is32 is high.
REQ-025 A push and a pop in the same cycle SHALL both take effect; count is updated by the net change.
REQ-026 When instr_ready is low, all instr* outputs SHALL hold stable while instr_valid is high.
REQ-027 On branch_valid, the FIFO SHALL empty at that edge; instr_valid SHALL be low next cycle; a same-cycle pop is discarded.
REQ-028 On branch_valid, fetch_addr SHALL become branch_target with the low log2(BUS_WIDTH/8) bits cleared.
REQ-029 On branch_valid, skip SHALL become branch_target[log2(BUS_WIDTH/8)-1:1].
REQ-030 If a read is outstanding at branch_valid (including one whose mem_rvalid arrives in the same cycle), its data SHALL be discarded via a drop flag.
REQ-031 The next mem_req after branch_valid SHALL issue no earlier than the cycle after that discarded mem_rvalid.
REQ-032 A second branch_valid before the new data arrives SHALL supersede the first; only the latest target is fetched.
REQ-033 When the FIFO holds only a 32-bit lead, instr_valid SHALL stay low until hw1 arrives; a straddling instruction is never split.
REQ-034 With zero wait states, sustained throughput SHALL be one read per 2 cycles.

Reset
REQ-035 While reset is high: mem_req=0, mem_addr=RESET_PC aligned, instr_valid=0, instr=0, instr_is32=0, instr_pc=0, FIFO empty, skip=RESET_PC[log2(BUS_WIDTH/8)-1:1], drop flag clear, nothing outstanding.
REQ-036 The first mem_req SHALL occur in the first cycle after reset deasserts.
REQ-037 reset asserted mid-read SHALL clear all state; a late mem_rvalid SHALL be ignored until the first post-reset mem_req.

Verification
REQ-038 Memory 0x08000010=0x67452301, 0x08000014=0xDDCCBBAA, BUS_WIDTH=32, instr_ready=1, branch to 0x08000010 -> instrs 0x2301@0x08000010, 0x6745@..12, 0xBBAA@..14, 0xDDCC@..16, all instr_is32=0.
REQ-039 Same memory, branch to 0x08000012 -> first instr 0x6745@0x08000012; 0x2301 is never presented.
REQ-040 Word 0x08000020=0xF000F7FF -> instr=0xF7FFF000, instr_is32=1, instr_pc=0x08000020, single transfer popping 2 halfwords.
REQ-041 Lead 0xF7FF at 0x08000022 and its second half in the next word, with a 3-cycle wait state -> instr_valid low until the second word arrives, then instr=0xF7FF<hw1>, instr_pc=0x08000022.
REQ-042 instr_ready=0 for 20 cycles -> FIFO fills to DEPTH with no overflow, mem_req stops, outputs stable; release -> in-order drain with no lost or duplicated halfword.
REQ-043 branch_valid while a read is outstanding; cover both BUS_WIDTH=32 and BUS_WIDTH=64 -> stale mem_rdata discarded, first instr_pc equals branch_target.
